// File: rtl/handshake_xfer_buf.sv
// Write-side FIFO that drains each buffered word to a downstream consumer
// over a 4-phase req/ack handshake, with a synchronised asynchronous ack.
module handshake_xfer_buf #(
    parameter int DW          = 32,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clka,
    input  logic                       rst,
    input  logic                       en_i,
    input  logic [DW-1:0]              data_i,
    input  logic                       clr_i,
    input  logic                       ack_i,
    output logic                       req_o,
    output logic [DW-1:0]              data_o,
    output logic                       done_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       ovf_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_LOW = 2'd2
    } state_t;

    state_t                 state_r;
    logic [SYNC_STAGES-1:0] ack_sync_r;
    logic                   ack_s;
    logic [DW-1:0]          mem_r [DEPTH];
    logic [AW-1:0]          wr_ptr_r;
    logic [AW-1:0]          rd_ptr_r;
    logic [CW-1:0]          count_r;
    logic                   req_r;
    logic [DW-1:0]          data_r;
    logic                   done_r;
    logic                   ovf_r;
    logic                   pop_s;
    logic                   push_s;
    logic                   drop_s;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
        if (ptr == AW'(DEPTH - 1)) begin
            return {AW{1'b0}};
        end else begin
            return ptr + AW'(1);
        end
    endfunction

    assign ack_s = ack_sync_r[SYNC_STAGES-1];

    // Pop is decided on registered occupancy, so a word pushed this cycle cannot leave this cycle.
    always_comb begin
        pop_s  = 1'b0;
        push_s = 1'b0;
        drop_s = 1'b0;
        if ((state_r == ST_IDLE) && (count_r != {CW{1'b0}}) && !ack_s) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        if (en_i && ((count_r != CW'(DEPTH)) || pop_s)) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        drop_s = en_i & ~push_s;
    end

    // Acknowledge synchroniser chain.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            ack_sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            ack_sync_r <= {ack_sync_r[SYNC_STAGES-2:0], ack_i};
        end
    end

    // Buffer storage; contents are don't-care while empty, so no reset.
    always_ff @(posedge clka) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= data_i;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= next_ptr(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky overflow flag; a drop outranks a clear in the same cycle.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (drop_s) begin
            ovf_r <= 1'b1;
        end else if (clr_i) begin
            ovf_r <= 1'b0;
        end
    end

    // Four-phase handshake controller with registered req/data/done.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            req_r   <= 1'b0;
            data_r  <= {DW{1'b0}};
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        data_r  <= mem_r[rd_ptr_r];
                        req_r   <= 1'b1;
                        state_r <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (ack_s) begin
                        req_r   <= 1'b0;
                        state_r <= ST_WAIT_LOW;
                    end
                end
                ST_WAIT_LOW: begin
                    if (!ack_s) begin
                        done_r  <= 1'b1;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    req_r   <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_o   = req_r;
    assign data_o  = data_r;
    assign done_o  = done_r;
    assign count_o = count_r;
    assign ovf_o   = ovf_r;
    assign full_o  = (count_r == CW'(DEPTH));
    assign empty_o = (count_r == {CW{1'b0}});

endmodule

// File: tb/tb_handshake_xfer_buf.sv
// Randomised and directed bench for handshake_xfer_buf against a queue-based
// reference model of the buffer and its req/ack protocol.
module tb_handshake_xfer_buf;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clka = 1'b0;
    logic          rst = 1'b1;
    logic          en_i = 1'b0;
    logic [DW-1:0] data_i = '0;
    logic          clr_i = 1'b0;
    logic          ack_i = 1'b0;
    logic          req_o, done_o, full_o, empty_o, ovf_o;
    logic [DW-1:0] data_o;
    logic [CW-1:0] count_o;

    int vectors = 0;
    int errors  = 0;

    // reference model state
    logic [DW-1:0] mq[$];
    logic          m_req, m_done, m_ovf;
    logic [DW-1:0] m_data;
    int            m_phase;
    logic [SYNC-1:0] m_sh;

    handshake_xfer_buf #(.DW(DW), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
        .clka(clka), .rst(rst), .en_i(en_i), .data_i(data_i), .clr_i(clr_i),
        .ack_i(ack_i), .req_o(req_o), .data_o(data_o), .done_o(done_o),
        .count_o(count_o), .full_o(full_o), .empty_o(empty_o), .ovf_o(ovf_o)
    );

    always #5 clka = ~clka;

    function automatic void model_clear();
        mq.delete();
        m_req = 1'b0; m_done = 1'b0; m_ovf = 1'b0;
        m_data = '0; m_phase = 0; m_sh = '0;
    endfunction

    // advance model with current inputs, then one clock edge
    task automatic tick();
        logic acks, pop, push, drop;
        if (rst) begin
            model_clear();
        end else begin
            acks = m_sh[SYNC-1];
            pop  = (m_phase == 0) && (mq.size() > 0) && !acks;
            push = en_i && ((mq.size() < DEPTH) || pop);
            drop = en_i && !push;
            m_done = 1'b0;
            if (pop) begin
                m_data = mq.pop_front(); m_req = 1'b1; m_phase = 1;
            end else if (m_phase == 1 && acks) begin
                m_req = 1'b0; m_phase = 2;
            end else if (m_phase == 2 && !acks) begin
                m_phase = 0; m_done = 1'b1;
            end
            if (push) mq.push_back(data_i);
            if (drop) m_ovf = 1'b1;
            else if (clr_i) m_ovf = 1'b0;
            m_sh = {m_sh[SYNC-2:0], ack_i};
        end
        @(posedge clka); #1;
    endtask

    task automatic wait_req(input logic lvl, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (req_o === lvl) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (done_o === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; en_i = 1'b0; clr_i = 1'b0; ack_i = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if (req_o !== 1'b0 || done_o !== 1'b0 || data_o !== '0) begin
            errors++; $display("FAIL reset_handshake: req=%b done=%b data=%h, required 0/0/0", req_o, done_o, data_o);
        end
        vectors++;
        if (count_o !== '0 || ovf_o !== 1'b0) begin
            errors++; $display("FAIL reset_count: count=%0d ovf=%b, required 0/0", count_o, ovf_o);
        end
        vectors++;
        if (empty_o !== 1'b1 || full_o !== 1'b0) begin
            errors++; $display("FAIL reset_flags: empty=%b full=%b, required 1/0", empty_o, full_o);
        end
        do_reset();
    endtask

    task automatic test_single();
        int ndone, first;
        en_i = 1'b1; data_i = 32'hA5A5_0001;
        tick();
        en_i = 1'b0;
        vectors++;
        if (req_o !== 1'b0 || count_o !== 3'd1) begin
            errors++; $display("FAIL single_edge1: req=%b count=%0d, required 0/1", req_o, count_o);
        end
        tick();
        vectors++;
        if (req_o !== 1'b1 || data_o !== 32'hA5A5_0001 || count_o !== 3'd0) begin
            errors++; $display("FAIL single_launch: req=%b data=%h count=%0d, required 1/a5a50001/0", req_o, data_o, count_o);
        end
        ack_i = 1'b1;
        tick(); tick();
        vectors++;
        if (req_o !== 1'b1) begin
            errors++; $display("FAIL single_ack_early: req=%b, required 1", req_o);
        end
        tick();
        vectors++;
        if (req_o !== 1'b0 || data_o !== 32'hA5A5_0001) begin
            errors++; $display("FAIL single_ack: req=%b data=%h, required 0/a5a50001", req_o, data_o);
        end
        ack_i = 1'b0;
        ndone = 0; first = -1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (done_o === 1'b1) begin
                ndone++;
                if (first < 0) first = i;
            end
        end
        vectors++;
        if (ndone != 1 || first != 3) begin
            errors++; $display("FAIL single_done: pulses=%0d at=%0d, required 1 at 3", ndone, first);
        end
    endtask

    task automatic test_burst();
        bit ok;
        ack_i = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            en_i = 1'b1; data_i = DW'(i);
            tick();
        end
        en_i = 1'b0;
        vectors++;
        if (count_o !== 3'd4 || ovf_o !== 1'b1 || full_o !== 1'b1 || req_o !== 1'b1 || data_o !== 32'd1) begin
            errors++; $display("FAIL burst_state: count=%0d ovf=%b full=%b req=%b data=%h, required 4/1/1/1/1",
                               count_o, ovf_o, full_o, req_o, data_o);
        end
        for (int k = 1; k <= 5; k++) begin
            wait_req(1'b1, ok);
            vectors++;
            if (!ok || data_o !== DW'(k)) begin
                errors++; $display("FAIL burst_order: got=%h ok=%b, required %h", data_o, ok, k);
            end
            ack_i = 1'b1;
            wait_req(1'b0, ok);
            ack_i = 1'b0;
            wait_done(ok);
            vectors++;
            if (!ok) begin
                errors++; $display("FAIL burst_done: no done pulse for word %0d, required pulse", k);
            end
        end
    endtask

    task automatic test_ovf_clear();
        ack_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            en_i = 1'b1; data_i = 32'h100 + DW'(i);
            tick();
        end
        en_i = 1'b1; clr_i = 1'b1; data_i = 32'hDEAD;
        tick();
        vectors++;
        if (ovf_o !== 1'b1 || count_o !== 3'd4) begin
            errors++; $display("FAIL ovf_drop_priority: ovf=%b count=%0d, required 1/4", ovf_o, count_o);
        end
        en_i = 1'b0;
        tick();
        clr_i = 1'b0;
        vectors++;
        if (ovf_o !== 1'b0) begin
            errors++; $display("FAIL ovf_clear: ovf=%b, required 0", ovf_o);
        end
    endtask

    task automatic test_full_pop();
        bit ok;
        ack_i = 1'b1;
        wait_req(1'b0, ok);
        ack_i = 1'b0;
        wait_done(ok);
        en_i = 1'b1; data_i = 32'hF00D;
        tick();
        en_i = 1'b0;
        vectors++;
        if (!ok || count_o !== 3'd4 || ovf_o !== 1'b0 || req_o !== 1'b1 || data_o !== 32'h101) begin
            errors++; $display("FAIL full_pop: ok=%b count=%0d ovf=%b req=%b data=%h, required 1/4/0/1/101",
                               ok, count_o, ovf_o, req_o, data_o);
        end
        vectors++;
        if (data_o !== m_data || int'(count_o) != mq.size()) begin
            errors++; $display("FAIL full_pop_model: data=%h count=%0d, required %h/%0d", data_o, count_o, m_data, mq.size());
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int launches;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            en_i = 1'b1; data_i = 32'h10 + DW'(i);
            tick();
        end
        en_i = 1'b0;
        vectors++;
        if (req_o !== 1'b1 || count_o !== 3'd3) begin
            errors++; $display("FAIL rstmid_pre: req=%b count=%0d, required 1/3", req_o, count_o);
        end
        ack_i = 1'b1;
        rst = 1'b1;
        #1;
        vectors++;
        if (req_o !== 1'b0 || count_o !== 3'd0 || data_o !== '0) begin
            errors++; $display("FAIL rstmid_async: req=%b count=%0d data=%h, required 0/0/0", req_o, count_o, data_o);
        end
        tick(); tick();
        rst = 1'b0;
        tick(); tick(); tick();
        en_i = 1'b1; data_i = 32'h55;
        tick();
        en_i = 1'b0;
        launches = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (req_o !== 1'b0) launches++;
        end
        vectors++;
        if (launches != 0 || count_o !== 3'd1) begin
            errors++; $display("FAIL rstmid_hold: launches=%0d count=%0d, required 0/1", launches, count_o);
        end
        ack_i = 1'b0;
        wait_req(1'b1, ok);
        vectors++;
        if (!ok || data_o !== 32'h55) begin
            errors++; $display("FAIL rstmid_launch: ok=%b data=%h, required 1/55", ok, data_o);
        end
        ack_i = 1'b1;
        wait_req(1'b0, ok);
        ack_i = 1'b0;
        wait_done(ok);
    endtask

    task automatic test_wrap();
        localparam int N = 3 * DEPTH + 1;
        logic [DW-1:0] expw[$];
        int pushed, delivered, ack_cnt;
        logic prev_req;
        do_reset();
        pushed = 0; delivered = 0; prev_req = 1'b0;
        ack_cnt = int'($urandom_range(0, 7));
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (pushed < N && mq.size() < DEPTH && $urandom_range(0, 1) == 1) begin
                en_i = 1'b1; data_i = $urandom;
                expw.push_back(data_i); pushed++;
            end else begin
                en_i = 1'b0;
            end
            if (req_o !== ack_i) begin
                if (ack_cnt == 0) begin
                    ack_i = req_o; ack_cnt = int'($urandom_range(0, 7));
                end else begin
                    ack_cnt--;
                end
            end
            tick();
            vectors++;
            if (req_o !== m_req || data_o !== m_data || done_o !== m_done || count_o !== CW'(mq.size()) ||
                ovf_o !== m_ovf || full_o !== (mq.size() == DEPTH) || empty_o !== (mq.size() == 0)) begin
                errors++; $display("FAIL wrap_cycle %0d: req=%b data=%h done=%b count=%0d ovf=%b, required %b/%h/%b/%0d/%b",
                                   cyc, req_o, data_o, done_o, count_o, ovf_o, m_req, m_data, m_done, mq.size(), m_ovf);
            end
            if (req_o === 1'b1 && prev_req === 1'b0) begin
                vectors++;
                if (delivered >= N || data_o !== expw[delivered]) begin
                    errors++; $display("FAIL wrap_order: word %0d got=%h", delivered, data_o);
                end
                delivered++;
            end
            prev_req = req_o;
            if (delivered == N && m_phase == 0 && !ack_i && !req_o) break;
        end
        en_i = 1'b0;
        vectors++;
        if (delivered != N) begin
            errors++; $display("FAIL wrap_count: delivered=%0d, required %0d", delivered, N);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single();
        test_burst();
        test_ovf_clear();
        test_full_pop();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/handshake_xfer_buf.md
HANDSHAKE_XFER_BUF -- requirements
Module: handshake_xfer_buf

Interface
REQ-001 Parameter DW, default 32: data word width, 1..64.
REQ-002 Parameter DEPTH, default 4: buffer entries, power of two, 2..16.
REQ-003 Parameter SYNC_STAGES, default 2: ack_i synchroniser flops, 2..4.
REQ-004 clka  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 en_i  input  1  write strobe; data_i is captured on every clka edge where en_i=1.
REQ-007 data_i  input  DW  write data.
REQ-008 clr_i  input  1  synchronous clear of ovf_o.
REQ-009 ack_i  input  1  downstream 4-phase acknowledge, asynchronous to clka.
REQ-010 req_o  output  1  downstream 4-phase request, registered.
REQ-011 data_o  output  DW  transfer data, registered, stable while req_o=1.
REQ-012 done_o  output  1  one-cycle pulse on handshake completion.
REQ-013 count_o  output  $clog2(DEPTH)+1  buffer occupancy, 0..DEPTH.
REQ-014 full_o / empty_o  output  1 each  count_o==DEPTH / count_o==0, combinational from count.
REQ-015 ovf_o  output  1  sticky flag for a dropped write.

Function
REQ-016 ack_i SHALL pass through SYNC_STAGES flops; only the final stage (ack_s) is used by the FSM.
REQ-017 Buffer SHALL be a circular FIFO with rd/wr pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-018 Push SHALL be accepted when en_i=1 and (count<DEPTH, or a pop occurs in the same cycle).
REQ-019 Push while full with no same-cycle pop SHALL drop data_i, leave FIFO unchanged, and set ovf_o=1 at the next edge.
REQ-020 ovf_o SHALL clear on clr_i=1 unless a drop occurs in the same cycle; a drop SHALL take priority.
REQ-021 FSM states: IDLE, REQ, WAIT_LOW.
REQ-022 IDLE -> REQ when count>0 and ack_s=0: pop the head into data_o, set req_o=1 at the same edge.
REQ-023 IDLE with ack_s=1 (protocol violation) SHALL NOT launch; the FSM remains in IDLE.
REQ-024 REQ -> WAIT_LOW when ack_s=1: req_o=0 at that edge; data_o holds its value.
REQ-025 WAIT_LOW -> IDLE when ack_s=0; done_o=1 for exactly that one cycle.
REQ-026 Minimum latency: en_i sampled at edge k into empty FIFO in IDLE -> req_o=1 after edge k+1.
REQ-027 Simultaneous push and pop SHALL leave count unchanged; a push into an empty FIFO is not poppable in the same cycle.
REQ-028 data_o SHALL change only on a pop; it holds the last transferred word indefinitely.
REQ-029 Words SHALL be delivered strictly in push order, with no duplication or loss except drops per REQ-019.

Reset
REQ-030 On rst=1, immediately and without a clock: req_o=0, data_o=0, done_o=0, ovf_o=0, count_o=0, pointers=0, sync flops=0, FSM=IDLE.
REQ-031 Reset mid-handshake SHALL discard buffered words; after release, the FSM waits in IDLE for ack_s=0 before any launch.
REQ-032 Buffer storage need not be reset; its contents are unobservable while empty.

Verification
REQ-033 Single word: push 0xA5A5_0001 in IDLE -> req_o=1 two edges later with data_o=0xA5A5_0001; ack_i=1 -> req_o=0 after SYNC_STAGES+1 edges; ack_i=0 -> done_o one-cycle pulse.
REQ-034 Burst and order: push 6 words 1..6 back-to-back with DEPTH=4 and ack_i held low -> words 1..5 are accepted (one is popped while the burst runs), word 6 is dropped, and ovf_o=1; completing handshakes delivers 1,2,3,4,5 in order.
REQ-035 Full with simultaneous pop: FIFO full and a pop in the same cycle as en_i -> write is accepted, count stays 4, ovf_o stays 0.
REQ-036 Overflow clear: ovf_o=1 with clr_i=1 and a simultaneous drop -> ovf_o stays 1; clr_i=1 alone -> ovf_o=0.
REQ-037 Reset mid-operation: assert rst while req_o=1 with count=3 -> req_o=0 and count_o=0 immediately; ack_i held high after release -> no launch until ack_i falls.
REQ-038 Wrap-around: 3*DEPTH+1 words with random ack_i delays of 0..7 cycles -> all words are delivered in order and pointers wrap correctly.
